// File: rtl/gray_pkg.sv
// Shared types and helpers for Gray-code stream handling.
package gray_pkg;

    typedef enum logic [2:0] {
        ST_FIRST,
        ST_UP,
        ST_DOWN,
        ST_HOLD,
        ST_ERR
    } st_e;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } fsm_e;

    localparam int GRAY_MAX_W = 64;
    localparam int CONS_W     = 4;

    // Binary is the XOR of every right shift of the Gray code; bits at or above w are ignored.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int unsigned           w
    );
        logic [GRAY_MAX_W-1:0] mask;
        logic [GRAY_MAX_W-1:0] gm;
        logic [GRAY_MAX_W-1:0] acc;
        mask = (w >= GRAY_MAX_W) ? '1 : ((GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1));
        gm   = g & mask;
        acc  = gm;
        for (int k = 1; k < GRAY_MAX_W; k++) begin
            acc = acc ^ (gm >> k);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gray_step_classifier.sv
// Combinational classification of a decoded sample against the previous one.
module gray_step_classifier
    import gray_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    input  logic             i_state,
    output logic [2:0]       o_status
);

    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    // Modulo-2^WIDTH neighbours, so the all-ones/zero wrap counts as a single step.
    assign w_inc = i_p + WIDTH'(1);
    assign w_dec = i_p - WIDTH'(1);

    always_comb begin
        o_status = ST_ERR;
        if (i_state == UNLOCKED) begin
            o_status = ST_FIRST;
        end else if (i_b == i_p) begin
            o_status = ST_HOLD;
        end else if (i_b == w_inc) begin
            o_status = ST_UP;
        end else if (i_b == w_dec) begin
            o_status = ST_DOWN;
        end
    end

endmodule

// File: rtl/gray_stream_decoder.sv
// Valid/ready Gray-code sample receiver: decodes, classifies, tracks lock and counts step errors.
module gray_stream_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ERR_CNT_W   = 8,
    parameter int LOSS_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_gray,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_binary,
    output logic [2:0]           out_status,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    fsm_e                 r_state;
    fsm_e                 w_state_next;
    logic [CONS_W-1:0]    r_cons;
    logic [CONS_W-1:0]    w_cons_next;
    logic [CONS_W:0]      w_cons_inc;
    logic [WIDTH-1:0]     r_prev_bin;
    logic [WIDTH-1:0]     w_bin;
    logic [2:0]           w_status;
    logic                 w_accept;
    logic                 w_is_err;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_binary;
    logic [2:0]           r_out_status;
    logic [ERR_CNT_W-1:0] r_err_count;

    assign in_ready   = !clear && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_bin      = WIDTH'(gray2bin(GRAY_MAX_W'(in_gray), WIDTH));
    assign w_is_err   = (w_status == ST_ERR);
    assign w_cons_inc = {1'b0, r_cons} + (CONS_W+1)'(1);

    gray_step_classifier #(
        .WIDTH (WIDTH)
    ) u_classifier (
        .i_b      (w_bin),
        .i_p      (r_prev_bin),
        .i_state  (r_state),
        .o_status (w_status)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= UNLOCKED;
            r_cons  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cons  <= w_cons_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cons_next  = r_cons;
        if (clear) begin
            w_state_next = UNLOCKED;
            w_cons_next  = '0;
        end else if (w_accept) begin
            if (r_state == UNLOCKED) begin
                w_state_next = LOCKED;
                w_cons_next  = '0;
            end else if (w_is_err) begin
                // The sample that hits the threshold still reports ERR; only the state drops.
                if (w_cons_inc >= (CONS_W+1)'(LOSS_THRESH)) begin
                    w_state_next = UNLOCKED;
                    w_cons_next  = '0;
                end else begin
                    w_cons_next  = w_cons_inc[CONS_W-1:0];
                end
            end else begin
                w_cons_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid  <= 1'b0;
            r_out_binary <= '0;
            r_out_status <= ST_FIRST;
            r_prev_bin   <= '0;
        end else if (clear) begin
            r_out_valid  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_binary <= w_bin;
            r_out_status <= w_status;
            r_prev_bin   <= w_bin;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_count <= '0;
        end else if (clear) begin
            r_err_count <= '0;
        end else if (w_accept && w_is_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_binary = r_out_binary;
    assign out_status = r_out_status;
    assign locked     = (r_state == LOCKED);
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Scoreboard bench for gray_stream_decoder with WIDTH=4, ERR_CNT_W=2, LOSS_THRESH=3.
module tb_gray_stream_decoder;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] in_gray = '0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_binary;
    logic [2:0] out_status;
    logic       locked;
    logic [1:0] err_count;

    typedef struct packed {
        logic [3:0] bin;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    int   cyc = 0;

    gray_stream_decoder #(
        .WIDTH       (4),
        .ERR_CNT_W   (2),
        .LOSS_THRESH (3)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_gray    (in_gray),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_binary (out_binary),
        .out_status (out_status),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] enc(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("OUT bin=%0d status=%0d (exp bin=%0d status=%0d)", out_binary, out_status, e.bin, e.st);
                chk("out_binary", 32'(out_binary), 32'(e.bin));
                chk("out_status", 32'(out_status), 32'(e.st));
                n_out++;
            end
        end
    end

    task automatic send(input logic [3:0] bin, input logic [2:0] st);
        int waits;
        bit ok;
        waits    = 0;
        ok       = 1'b1;
        in_gray  = enc(bin);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            waits++;
            if (waits > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (ok) sb.push_back({bin, st});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          nerr;
        logic [3:0]  sat_bin [11];
        logic [2:0]  sat_st  [11];

        sat_bin = '{4'd0, 4'd5, 4'd6, 4'd10, 4'd11, 4'd1, 4'd2, 4'd9, 4'd8, 4'd14, 4'd14};
        sat_st  = '{ST_FIRST, ST_ERR, ST_UP, ST_ERR, ST_UP, ST_ERR, ST_UP, ST_ERR, ST_DOWN, ST_ERR, ST_HOLD};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_binary", 32'(out_binary), 32'd0);
        chk("rst_out_status", 32'(out_status), 32'(ST_FIRST));
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Nominal up-count, one per cycle
        t0 = cyc;
        send(4'd0, ST_FIRST);
        chk("locked_after_first", 32'(locked), 32'd1);
        send(4'd1, ST_UP);
        send(4'd2, ST_UP);
        send(4'd3, ST_UP);
        chk("throughput_cycles", 32'(cyc - t0), 32'd4);
        repeat (2) @(posedge clk);
        #1;
        chk("nominal_drained", 32'(sb.size()), 32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Wrap and direction
        do_clear();
        send(4'd15, ST_FIRST);
        send(4'd0, ST_UP);
        send(4'd15, ST_DOWN);
        send(4'd15, ST_HOLD);
        chk("wrap_err_count", 32'(err_count), 32'd0);

        // Step errors, loss of lock, re-lock
        do_clear();
        send(4'd1, ST_FIRST);
        send(4'd6, ST_ERR);
        chk("loss_locked_1", 32'(locked), 32'd1);
        send(4'd0, ST_ERR);
        chk("loss_locked_2", 32'(locked), 32'd1);
        send(4'd12, ST_ERR);
        chk("loss_err_count", 32'(err_count), 32'd3);
        chk("loss_locked_3", 32'(locked), 32'd0);
        send(4'd13, ST_FIRST);
        chk("relock", 32'(locked), 32'd1);

        // Backpressure
        do_clear();
        out_ready = 1'b0;
        send(4'd1, ST_FIRST);
        in_gray  = enc(4'd2);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_bin", 32'(out_binary), 32'd1);
            chk("bp_hold_status", 32'(out_status), 32'(ST_FIRST));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", 32'(in_ready), 32'd1);
        sb.push_back({4'd2, 3'(ST_UP)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_bin", 32'(out_binary), 32'd2);
        chk("bp_next_status", 32'(out_status), 32'(ST_UP));

        // Saturation with scattered errors
        do_clear();
        nerr = 0;
        for (int i = 0; i < 11; i++) begin
            send(sat_bin[i], sat_st[i]);
            if (sat_st[i] == ST_ERR) nerr++;
            chk("sat_err_count", 32'(err_count), (nerr > 3) ? 32'd3 : 32'(nerr));
        end
        chk("sat_locked", 32'(locked), 32'd1);

        // Clear with a sample offered
        in_gray  = enc(4'd3);
        in_valid = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_locked", 32'(locked), 32'd0);
        send(4'd3, ST_FIRST);

        // Asynchronous reset mid-stream
        send(4'd9, ST_ERR);
        chk("pre_rst_err_count", 32'(err_count), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        chk("arst_out_binary", 32'(out_binary), 32'd0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send(4'd7, ST_FIRST);
        chk("post_rst_locked", 32'(locked), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("total_outputs", 32'(n_out), 32'd28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_stream_decoder.md
Name: gray_stream_decoder

Overview:
Sequential receiver for a stream of WIDTH-bit Gray-coded samples, such as encoder positions or CDC pointers, delivered with a valid/ready handshake. Each accepted sample is decoded to binary and classified against the previous sample as first, up, down, hold or step error. Results leave through a registered, backpressurable output stage. The block tracks lock state and maintains a saturating error count for status logic.

Parameters:
WIDTH, 8, code width in bits; legal range is WIDTH >= 2.
ERR_CNT_W, 8, width of the saturating error counter.
LOSS_THRESH, 3, number of consecutive step errors that forces the block back to UNLOCKED; legal range is 1..15.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rstn  input  1  asynchronous active-low reset.
in_valid  input  1  in_gray holds a sample.
in_ready  output  1  block can accept a sample this cycle.
in_gray  input  WIDTH  Gray-coded sample.
clear  input  1  synchronous tracking clear.
out_valid  output  1  output register holds a result.
out_ready  input  1  downstream consumes the result.
out_binary  output  WIDTH  decoded binary value.
out_status  output  3  classification of the sample, using the st_e enum.
locked  output  1  FSM is in LOCKED.
err_count  output  ERR_CNT_W  saturating count of STEP_ERR results.

Behaviour:
- Reset is asynchronous and active-low. On reset: out_valid=0, out_binary=0, out_status=ST_FIRST, locked=0, err_count=0, prev_bin=0, consecutive-error counter=0, FSM=UNLOCKED.
- Decode: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i], evaluated MSB down to bit 0. The decode is combinational on in_gray and feeds the registered output.
- Handshake:
  - in_ready = !clear && (!out_valid || out_ready).
  - A sample is accepted when in_valid && in_ready.
  - Latency is 1 cycle: out_valid rises on the edge that accepts the sample.
  - While out_valid=1 && out_ready=0, out_binary and out_status are held stable.
  - Full throughput is one sample per cycle when out_ready=1.
- out_valid clears on an edge with out_ready=1 and no new accept.
- Classification: let b = decoded sample, p = prev_bin, arithmetic modulo 2^WIDTH.
  - FSM in UNLOCKED: ST_FIRST.
  - FSM in LOCKED, b == p: ST_HOLD.
  - FSM in LOCKED, b == p+1: ST_UP. Wrap applies, e.g. p=2^W-1 with b=0 is ST_UP.
  - FSM in LOCKED, b == p-1: ST_DOWN.
  - FSM in LOCKED, anything else: ST_ERR. A single-bit Gray difference alone does not qualify as a step.
- prev_bin <= b on every accept, including ST_ERR; the tracker resynchronises to the latest sample.
- FSM states:
  - UNLOCKED -> LOCKED on any accept.
  - In LOCKED, ST_ERR increments the consecutive-error counter; any non-ERR result zeroes it.
  - When the counter reaches LOSS_THRESH on an accept, the FSM moves to UNLOCKED and the counter zeroes. That sample still reports ST_ERR.
- err_count increments on each ST_ERR and saturates at 2^ERR_CNT_W-1.
- locked is a registered view of the FSM state.
- clear=1 (synchronous, highest priority below reset):
  - FSM goes to UNLOCKED; err_count, the consecutive counter and out_valid all go to 0.
  - No accept happens in that cycle; in_ready is 0.
  - A pending output result is discarded.
- Reset asserted mid-stream: outputs drop immediately to reset values. The first sample after reset reports ST_FIRST.

Decomposition:
- Package gray_pkg holds:
  - typedef enum logic [2:0] st_e {ST_FIRST, ST_UP, ST_DOWN, ST_HOLD, ST_ERR}
  - typedef enum logic fsm_e {UNLOCKED, LOCKED}
  - function gray2bin parameterised by WIDTH, shareable with other Gray-code blocks
- One natural sub-module: gray_step_classifier. It is combinational and takes b, p and state, returning st_e. Everything else lives in the top level: handshake, registers, FSM and counters.

Test Plan:
(All scenarios use WIDTH=4 and LOSS_THRESH=3 unless noted.)
- Nominal up-count: in_gray 0000, 0001, 0011, 0010 back-to-back with out_ready=1 -> out_binary 0,1,2,3 with status FIRST, UP, UP, UP; locked=1 after the first accept; one result per cycle.
- Wrap and direction: in_gray 1000 (15), 0000 (0), 1000 (15), 1000 -> statuses FIRST, UP, DOWN, HOLD; err_count=0.
- Step error, loss of lock and re-lock:
  - Sequence 0001 (1), 0101 (6), 0000 (0), 1010 (12) -> FIRST, ERR, ERR, ERR.
  - err_count=3 and locked=0 after the third ERR.
  - Next 1011 (13) -> FIRST, locked=1.
- Backpressure: out_ready=0 with in_valid=1 -> in_ready=0 after the first accept; out_binary/out_status stay stable for 5 cycles. Raising out_ready -> the held result is consumed and the next sample is accepted in the same cycle.
- Saturation and clear: ERR_CNT_W=2 with 5 scattered ERRs -> err_count stays at 3. Then clear=1 for one cycle with in_valid=1 -> in_ready=0, err_count=0, out_valid=0, locked=0, and the next accept reports FIRST.
- Async reset mid-stream: assert rstn=0 between clock edges while out_valid=1 -> out_valid, locked and err_count are 0 immediately. After release, the first sample reports FIRST.
